vg_vec_timer_seq: RTL and testbench

- Parametrised, fully synchronous successor to the vector generator timing controller.
- Accepts decoded vector-generator instructions as single-cycle strobes and runs each vector through a normalisation phase and a draw phase. The draw phase uses an internal duration timer, scaled by binary scale plus normalisation shift.
- Also handles CNTR, SCALE/STAT loads and the halt latch.
- Sits between the VG instruction fetch/decode state machine and the X/Y DAC integrators. Replaces the external STOP feedback with its own timer.

---
 rtl/vg_vec_timer_seq.sv | 253 +++++++++++++++++++++++++
 tb/tb_vg_vec_timer_seq.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/vg_vec_timer_seq.sv
// Vector generator timing controller: sequences VCTR/SVEC through NORM and DRAW,
// runs CNTR hold, SCALE/STAT loads and the halt latch, timing draws internally.
module vg_vec_timer_seq #(
  parameter int DV_WIDTH      = 13,
  parameter int SCALE_WIDTH   = 3,
  parameter int TIMER_WIDTH   = 12,
  parameter int CENTER_CYCLES = 16
) (
  input  logic                   clk_12MHz,
  input  logic                   RESET,
  input  logic                   op_valid,
  input  logic [2:0]             op,
  input  logic [DV_WIDTH-1:0]    dvx,
  input  logic [DV_WIDTH-1:0]    dvy,
  input  logic                   vggo,
  input  logic                   vgrst,
  output logic                   ready,
  output logic                   go,
  output logic                   vctr,
  output logic                   cntr,
  output logic                   norm,
  output logic                   halt,
  output logic [DV_WIDTH-1:0]    dvx_out,
  output logic [DV_WIDTH-1:0]    dvy_out,
  output logic [7:0]             lin_scale,
  output logic [SCALE_WIDTH-1:0] binary_scale,
  output logic                   statld,
  output logic                   scaleld,
  output logic                   done
);

  localparam int SUM_W   = $clog2(DV_WIDTH + 2**SCALE_WIDTH);
  localparam int SHIFT_W = $clog2(DV_WIDTH - 1);
  localparam int CNT_W   = (CENTER_CYCLES > 1) ? $clog2(CENTER_CYCLES) : 1;
  localparam int MSB     = DV_WIDTH - 1;

  localparam logic [SHIFT_W-1:0]     SHIFT_MAX = SHIFT_W'(DV_WIDTH - 2);
  localparam logic [CNT_W-1:0]       CNT_LOAD  = CNT_W'(CENTER_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] FULL_LEN  = '1;
  localparam logic [TIMER_WIDTH-1:0] ONE_LEN   = TIMER_WIDTH'(1);

  localparam logic [2:0] OP_VCTR  = 3'b000;
  localparam logic [2:0] OP_HALT  = 3'b001;
  localparam logic [2:0] OP_SVEC  = 3'b010;
  localparam logic [2:0] OP_SCALE = 3'b011;
  localparam logic [2:0] OP_CNTR  = 3'b100;

  typedef enum logic [2:0] {
    S_HALTED,
    S_IDLE,
    S_NORM,
    S_DRAW,
    S_CENTER
  } state_t;

  state_t                  state_q, state_d;
  logic                    halt_q, halt_d;
  logic [SCALE_WIDTH-1:0]  bscale_q, bscale_d;
  logic [7:0]              lin_q, lin_d;
  logic signed [DV_WIDTH-1:0] dvx_q, dvx_d;
  logic signed [DV_WIDTH-1:0] dvy_q, dvy_d;
  logic [SHIFT_W-1:0]      shift_q, shift_d;
  logic [TIMER_WIDTH-1:0]  timer_q, timer_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    statld_q, statld_d;
  logic                    scaleld_q, scaleld_d;
  logic                    done_q, done_d;
  logic [SUM_W-1:0]        total_shift;
  logic                    norm_exit;

  // Full-scale duration divided by 2^sh; never shorter than one cycle.
  function automatic logic [TIMER_WIDTH-1:0] draw_len(input logic [SUM_W-1:0] sh);
    logic [TIMER_WIDTH-1:0] len;
    if (int'(sh) >= TIMER_WIDTH) begin
      len = ONE_LEN;
    end else begin
      len = FULL_LEN >> sh;
      if (len == '0) len = ONE_LEN;
    end
    return len;
  endfunction

  assign total_shift = SUM_W'(bscale_q) + SUM_W'(shift_q);
  assign norm_exit   = (dvx_q[MSB] != dvx_q[MSB-1]) ||
                       (dvy_q[MSB] != dvy_q[MSB-1]) ||
                       (shift_q == SHIFT_MAX);

  always_comb begin
    state_d   = state_q;
    halt_d    = halt_q;
    bscale_d  = bscale_q;
    lin_d     = lin_q;
    dvx_d     = dvx_q;
    dvy_d     = dvy_q;
    shift_d   = shift_q;
    timer_d   = timer_q;
    cnt_d     = cnt_q;
    statld_d  = 1'b0;
    scaleld_d = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      S_HALTED: begin
        if (vggo) begin
          state_d = S_IDLE;
          halt_d  = 1'b0;
        end
      end

      S_IDLE: begin
        if (op_valid) begin
          case (op)
            OP_HALT: begin
              state_d = S_HALTED;
              halt_d  = 1'b1;
            end
            OP_SCALE: begin
              // The operand MSB selects SCALE over STAT.
              if (dvy[MSB]) begin
                bscale_d  = dvy[8+SCALE_WIDTH-1:8];
                lin_d     = dvy[7:0];
                scaleld_d = 1'b1;
              end else begin
                statld_d = 1'b1;
              end
            end
            OP_VCTR: begin
              dvx_d   = dvx;
              dvy_d   = dvy;
              shift_d = '0;
              state_d = S_NORM;
            end
            OP_SVEC: begin
              dvx_d   = dvx;
              dvy_d   = dvy;
              shift_d = '0;
              timer_d = draw_len(SUM_W'(bscale_q));
              state_d = S_DRAW;
            end
            OP_CNTR: begin
              dvx_d   = '0;
              dvy_d   = '0;
              cnt_d   = CNT_LOAD;
              state_d = S_CENTER;
            end
            default: ;
          endcase
        end
      end

      S_NORM: begin
        if (norm_exit) begin
          timer_d = draw_len(total_shift);
          state_d = S_DRAW;
        end else begin
          dvx_d   = dvx_q <<< 1;
          dvy_d   = dvy_q <<< 1;
          shift_d = shift_q + SHIFT_W'(1);
        end
      end

      S_DRAW: begin
        if (timer_q <= ONE_LEN) begin
          timer_d = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q - ONE_LEN;
        end
      end

      S_CENTER: begin
        if (cnt_q == '0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = S_HALTED;
        halt_d  = 1'b1;
      end
    endcase

    // CPU reset aborts everything; a simultaneous start still wins the halt latch.
    if (vgrst) begin
      bscale_d  = '0;
      lin_d     = lin_q;
      dvx_d     = dvx_q;
      dvy_d     = dvy_q;
      shift_d   = '0;
      timer_d   = '0;
      cnt_d     = '0;
      statld_d  = 1'b0;
      scaleld_d = 1'b0;
      done_d    = 1'b0;
      if (vggo) begin
        state_d = S_IDLE;
        halt_d  = 1'b0;
      end else begin
        state_d = S_HALTED;
        halt_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_12MHz or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_HALTED;
      halt_q    <= 1'b1;
      bscale_q  <= '0;
      lin_q     <= '0;
      dvx_q     <= '0;
      dvy_q     <= '0;
      shift_q   <= '0;
      timer_q   <= '0;
      cnt_q     <= '0;
      statld_q  <= 1'b0;
      scaleld_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      halt_q    <= halt_d;
      bscale_q  <= bscale_d;
      lin_q     <= lin_d;
      dvx_q     <= dvx_d;
      dvy_q     <= dvy_d;
      shift_q   <= shift_d;
      timer_q   <= timer_d;
      cnt_q     <= cnt_d;
      statld_q  <= statld_d;
      scaleld_q <= scaleld_d;
      done_q    <= done_d;
    end
  end

  assign ready        = (state_q == S_IDLE);
  assign go           = (state_q == S_DRAW);
  assign vctr         = (state_q == S_NORM) || (state_q == S_DRAW);
  assign cntr         = (state_q == S_CENTER);
  assign norm         = (state_q == S_NORM);
  assign halt         = halt_q;
  assign dvx_out      = dvx_q;
  assign dvy_out      = dvy_q;
  assign lin_scale    = lin_q;
  assign binary_scale = bscale_q;
  assign statld       = statld_q;
  assign scaleld      = scaleld_q;
  assign done         = done_q;

endmodule

// File: tb/tb_vg_vec_timer_seq.sv
// Directed bench for vg_vec_timer_seq: reset, normalised and scaled vectors,
// saturation, centre hold, halt and CPU-reset abort.
module tb_vg_vec_timer_seq;

  logic        clk_12MHz = 1'b0;
  logic        RESET;
  logic        op_valid;
  logic [2:0]  op;
  logic [12:0] dvx, dvy;
  logic        vggo, vgrst;
  logic        ready, go, vctr, cntr, norm, halt;
  logic [12:0] dvx_out, dvy_out;
  logic [7:0]  lin_scale;
  logic [2:0]  binary_scale;
  logic        statld, scaleld, done;

  int total = 0;
  int fails = 0;
  int n;

  vg_vec_timer_seq dut (
    .clk_12MHz(clk_12MHz), .RESET(RESET), .op_valid(op_valid), .op(op),
    .dvx(dvx), .dvy(dvy), .vggo(vggo), .vgrst(vgrst),
    .ready(ready), .go(go), .vctr(vctr), .cntr(cntr), .norm(norm), .halt(halt),
    .dvx_out(dvx_out), .dvy_out(dvy_out), .lin_scale(lin_scale),
    .binary_scale(binary_scale), .statld(statld), .scaleld(scaleld), .done(done)
  );

  always #5 clk_12MHz = ~clk_12MHz;

  task automatic tick();
    @(posedge clk_12MHz);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [12:0] x, input logic [12:0] y);
    op_valid = 1'b1; op = o; dvx = x; dvy = y;
    tick();
    op_valid = 1'b0; op = 3'b000; dvx = '0; dvy = '0;
  endtask

  function automatic logic sel(input int which);
    case (which)
      0:       return norm;
      1:       return go;
      default: return cntr;
    endcase
  endfunction

  // Counts consecutive cycles the selected output stays high, bounded.
  task automatic count_high(input int which, input int limit, output int cnt);
    cnt = 0;
    while (sel(which) && cnt < limit) begin
      cnt++;
      tick();
    end
  endtask

  initial begin
    RESET = 1'b1; op_valid = 1'b0; op = '0; dvx = '0; dvy = '0; vggo = 1'b0; vgrst = 1'b0;
    tick(); tick();
    chk("rst_halt", 32'(halt), 32'd1);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_go", 32'(go), 32'd0);
    chk("rst_bscale", 32'(binary_scale), 32'd0);
    chk("rst_dvx", 32'(dvx_out), 32'd0);
    RESET = 1'b0;
    tick();

    // Instruction while halted is ignored
    issue(3'b000, 13'h0040, 13'h0000);
    chk("halted_ignore_norm", 32'(norm), 32'd0);
    chk("halted_ignore_dvx", 32'(dvx_out), 32'd0);
    chk("halted_ignore_halt", 32'(halt), 32'd1);

    vggo = 1'b1; tick(); vggo = 1'b0;
    chk("go_halt", 32'(halt), 32'd0);
    chk("go_ready", 32'(ready), 32'd1);

    // Normalised VCTR: 5 shifts, 4095>>5 = 127 draw cycles
    issue(3'b000, 13'h0040, 13'h0000);
    chk("vctr_vctr", 32'(vctr), 32'd1);
    count_high(0, 50, n);
    chk("vctr_norm_cycles", 32'(n), 32'd6);
    chk("vctr_dvx_out", 32'(dvx_out), 32'h0800);
    count_high(1, 5000, n);
    chk("vctr_go_cycles", 32'(n), 32'd127);
    chk("vctr_done", 32'(done), 32'd1);
    chk("vctr_ready", 32'(ready), 32'd1);
    tick();
    chk("vctr_done_pulse", 32'(done), 32'd0);

    // SCALE load then STAT
    issue(3'b011, 13'h0000, 13'h1203);
    chk("scale_ld", 32'(scaleld), 32'd1);
    chk("scale_bs", 32'(binary_scale), 32'd2);
    chk("scale_lin", 32'(lin_scale), 32'h03);
    tick();
    chk("scale_ld_pulse", 32'(scaleld), 32'd0);
    issue(3'b011, 13'h0000, 13'h0005);
    chk("stat_ld", 32'(statld), 32'd1);
    chk("stat_scaleld", 32'(scaleld), 32'd0);
    chk("stat_bs_kept", 32'(binary_scale), 32'd2);

    // SVEC at scale 2: 4095>>2 = 1023, no NORM
    issue(3'b010, 13'h0FFF, 13'h0000);
    chk("svec_norm", 32'(norm), 32'd0);
    count_high(1, 5000, n);
    chk("svec_go_cycles", 32'(n), 32'd1023);
    chk("svec_done", 32'(done), 32'd1);

    // Saturation: scale 7, zero vector, shift 11 -> len 1
    issue(3'b011, 13'h0000, 13'h1700);
    chk("sat_bs", 32'(binary_scale), 32'd7);
    issue(3'b000, 13'h0000, 13'h0000);
    count_high(0, 50, n);
    chk("sat_norm_cycles", 32'(n), 32'd12);
    count_high(1, 50, n);
    chk("sat_go_cycles", 32'(n), 32'd1);
    chk("sat_done", 32'(done), 32'd1);

    // Prime non-zero deltas, then CNTR clears them; SCALE during CNTR ignored
    issue(3'b010, 13'h0123, 13'h0456);
    count_high(1, 50, n);
    chk("pre_cntr_dvx", 32'(dvx_out), 32'h0123);
    issue(3'b100, 13'h0000, 13'h0000);
    chk("cntr_dvx_zero", 32'(dvx_out), 32'd0);
    chk("cntr_dvy_zero", 32'(dvy_out), 32'd0);
    n = 0;
    while (cntr && n < 40) begin
      n++;
      if (n == 3) begin
        op_valid = 1'b1; op = 3'b011; dvy = 13'h1105;
      end else begin
        op_valid = 1'b0; op = 3'b000; dvy = '0;
      end
      tick();
    end
    op_valid = 1'b0; op = 3'b000; dvy = '0;
    chk("cntr_cycles", 32'(n), 32'd16);
    chk("cntr_done", 32'(done), 32'd1);
    chk("cntr_ignore_bs", 32'(binary_scale), 32'd7);
    chk("cntr_ignore_lin", 32'(lin_scale), 32'h00);

    // HALT
    issue(3'b001, 13'h0000, 13'h0000);
    chk("halt_halt", 32'(halt), 32'd1);
    chk("halt_ready", 32'(ready), 32'd0);

    // Abort mid-DRAW
    vggo = 1'b1; tick(); vggo = 1'b0;
    issue(3'b011, 13'h0000, 13'h1100);
    issue(3'b010, 13'h0001, 13'h0000);
    for (int i = 0; i < 10; i++) tick();
    chk("abort_pre_go", 32'(go), 32'd1);
    vgrst = 1'b1; tick(); vgrst = 1'b0;
    chk("abort_go", 32'(go), 32'd0);
    chk("abort_halt", 32'(halt), 32'd1);
    chk("abort_bs", 32'(binary_scale), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    tick();
    chk("abort_done_late", 32'(done), 32'd0);

    // Simultaneous vgrst + vggo
    vggo = 1'b1; tick(); vggo = 1'b0;
    issue(3'b011, 13'h0000, 13'h1300);
    chk("sim_bs_pre", 32'(binary_scale), 32'd3);
    vgrst = 1'b1; vggo = 1'b1; tick(); vgrst = 1'b0; vggo = 1'b0;
    chk("sim_ready", 32'(ready), 32'd1);
    chk("sim_halt", 32'(halt), 32'd0);
    chk("sim_bs", 32'(binary_scale), 32'd0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
